// File: rtl/mem_reg_pkg.sv
// Shared types and defaults for the memory / register-file transfer subsystem.
package mem_reg_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_MEM_AW = 10;
  localparam int DEF_REG_AW = 5;
  localparam int DEF_NUM_RD = 3;

  localparam logic XFER_LOAD  = 1'b0;
  localparam logic XFER_STORE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } xfer_state_e;

endpackage

// File: rtl/mem_reg_regfile.sv
// Register file: NRD combinational read ports, one write port with same-cycle
// write-to-read forwarding, synchronous clear.
module mem_reg_regfile
  import mem_reg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int NRD    = DEF_NUM_RD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [REG_AW-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [NRD*REG_AW-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs [1<<REG_AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < (1 << REG_AW); i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [REG_AW-1:0] ra;
    assign ra = raddr[g*REG_AW +: REG_AW];
    assign rdata[g*DATA_W +: DATA_W] = (wr_en && waddr == ra) ? wdata : regs[ra];
  end

endmodule

// File: rtl/mem_reg_xfer.sv
// Data memory plus register file with a burst engine copying words between them.
// Host access owns both arrays in IDLE; the engine owns them while busy.
module mem_reg_xfer
  import mem_reg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MEM_AW = DEF_MEM_AW,
  parameter int REG_AW = DEF_REG_AW,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_wr_en,
  input  logic [MEM_AW-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_wdata,
  output logic [DATA_W-1:0]        mem_rdata,
  input  logic                     reg_wr_en,
  input  logic [REG_AW-1:0]        reg_waddr,
  input  logic [DATA_W-1:0]        reg_wdata,
  input  logic [NUM_RD*REG_AW-1:0] reg_raddr,
  output logic [NUM_RD*DATA_W-1:0] reg_rdata,
  input  logic                     xfer_start,
  input  logic                     xfer_dir,
  input  logic [MEM_AW-1:0]        xfer_mem_base,
  input  logic [REG_AW-1:0]        xfer_reg_base,
  input  logic [REG_AW:0]          xfer_len,
  output logic                     xfer_busy,
  output logic                     xfer_done,
  output logic                     xfer_err
);

  localparam int              MEM_DEPTH = 1 << MEM_AW;
  localparam logic [REG_AW:0] REG_DEPTH = {1'b1, {REG_AW{1'b0}}};
  localparam logic [REG_AW:0] LEN_ONE   = {{REG_AW{1'b0}}, 1'b1};

  xfer_state_e       state;
  logic              dir_q;
  logic [MEM_AW-1:0] mb_q;
  logic [REG_AW-1:0] rb_q;
  logic [REG_AW:0]   len_q, k;
  logic              eng_wpend;
  logic [REG_AW-1:0] eng_waddr;
  logic [DATA_W-1:0] eng_rdata, eng_rd;
  logic              busy_q, done_q, err_q, err_hold;

  logic              idle, last, start_bad, to_done;
  logic [MEM_AW-1:0] eng_maddr, ma;
  logic [REG_AW-1:0] eng_raddr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wd;

  assign idle      = (state == IDLE);
  assign last      = (k == len_q - LEN_ONE);
  assign eng_maddr = mb_q + MEM_AW'(k);
  assign eng_raddr = rb_q + REG_AW'(k);
  assign start_bad = xfer_start && (!idle || xfer_len > REG_DEPTH);
  assign to_done   = (idle && xfer_start && xfer_len == '0)
                   || (state == RUN && dir_q == XFER_STORE && last)
                   || (state == DRAIN);

  // Single-port memory: the engine takes the address whenever it is not idle.
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  assign ma     = idle ? mem_addr : eng_maddr;
  assign mem_we = !rst && (idle ? mem_wr_en : (state == RUN && dir_q == XFER_STORE));
  assign mem_wd = idle ? mem_wdata : eng_rd;

  always_ff @(posedge clk) begin
    if (mem_we) mem[ma] <= mem_wd;
    eng_rdata <= mem[ma];
  end

  always_ff @(posedge clk) begin
    if (rst)       mem_rdata <= '0;
    else if (idle) mem_rdata <= mem[ma];
  end

  // Extra read port beyond the host ones feeds store data to the memory.
  logic [(NUM_RD+1)*DATA_W-1:0] rf_rdata;
  logic                         rf_we;
  logic [REG_AW-1:0]            rf_waddr;
  logic [DATA_W-1:0]            rf_wdata;

  assign rf_we    = idle ? reg_wr_en : (eng_wpend && (state == RUN || state == DRAIN));
  assign rf_waddr = idle ? reg_waddr : eng_waddr;
  assign rf_wdata = idle ? reg_wdata : eng_rdata;

  mem_reg_regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .NRD    (NUM_RD + 1)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .wr_en (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr ({eng_raddr, reg_raddr}),
    .rdata (rf_rdata)
  );

  assign reg_rdata = rf_rdata[NUM_RD*DATA_W-1:0];
  assign eng_rd    = rf_rdata[NUM_RD*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dir_q     <= XFER_LOAD;
      mb_q      <= '0;
      rb_q      <= '0;
      len_q     <= '0;
      k         <= '0;
      eng_wpend <= 1'b0;
      eng_waddr <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_hold  <= 1'b0;
    end else begin
      done_q   <= to_done;
      // A rejection landing on the done cycle is pushed back by one cycle.
      err_q    <= (start_bad || err_hold) && !to_done;
      err_hold <= (start_bad || err_hold) && to_done;
      case (state)
        IDLE: begin
          if (xfer_start && xfer_len <= REG_DEPTH) begin
            busy_q <= 1'b1;
            if (xfer_len == '0) begin
              state <= DONE;
            end else begin
              state <= RUN;
              dir_q <= xfer_dir;
              mb_q  <= xfer_mem_base;
              rb_q  <= xfer_reg_base;
              len_q <= xfer_len;
              k     <= '0;
            end
          end
        end
        RUN: begin
          k         <= k + LEN_ONE;
          eng_wpend <= (dir_q == XFER_LOAD);
          eng_waddr <= eng_raddr;
          if (last) state <= (dir_q == XFER_LOAD) ? DRAIN : DONE;
        end
        DRAIN: begin
          eng_wpend <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign xfer_busy = busy_q;
  assign xfer_done = done_q;
  assign xfer_err  = err_q;

endmodule

// File: tb/tb_mem_reg_xfer.sv
// Scoreboarded bench: expected done/err events are queued at issue time and
// popped by a monitor; array contents are checked against a word-level model.
module tb_mem_reg_xfer;

  localparam int DW = 32, MAW = 10, RAW = 5, NRD = 3;
  localparam int MDEP = 1 << MAW, RDEP = 1 << RAW;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_wr_en;
  logic [MAW-1:0]    mem_addr;
  logic [DW-1:0]     mem_wdata, mem_rdata;
  logic              reg_wr_en;
  logic [RAW-1:0]    reg_waddr;
  logic [DW-1:0]     reg_wdata;
  logic [NRD*RAW-1:0] reg_raddr;
  logic [NRD*DW-1:0] reg_rdata;
  logic              xfer_start, xfer_dir;
  logic [MAW-1:0]    xfer_mem_base;
  logic [RAW-1:0]    xfer_reg_base;
  logic [RAW:0]      xfer_len;
  logic              xfer_busy, xfer_done, xfer_err;

  mem_reg_xfer dut (
    .clk(clk), .rst(rst),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .reg_wr_en(reg_wr_en), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .xfer_start(xfer_start), .xfer_dir(xfer_dir), .xfer_mem_base(xfer_mem_base),
    .xfer_reg_base(xfer_reg_base), .xfer_len(xfer_len),
    .xfer_busy(xfer_busy), .xfer_done(xfer_done), .xfer_err(xfer_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;
  logic [DW-1:0] m_mem [MDEP];
  logic [DW-1:0] m_reg [RDEP];

  typedef struct {bit is_err; int cyc;} ev_t;
  ev_t exp_q[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_ev(bit is_err, int c);
    ev_t ev;
    int i = 0;
    ev.is_err = is_err;
    ev.cyc = c;
    while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
    exp_q.insert(i, ev);
  endfunction

  always @(negedge clk) begin
    if (!rst && (xfer_done || xfer_err)) begin
      ev_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: done=%0b err=%0b at cycle %0d, none required",
                 xfer_done, xfer_err, cyc);
      end else begin
        e = exp_q.pop_front();
        if ((xfer_done && xfer_err) || e.is_err != xfer_err || e.cyc != cyc) begin
          n_fail++;
          $display("FAIL xfer_event: got done=%0b err=%0b at cycle %0d, required %s at cycle %0d",
                   xfer_done, xfer_err, cyc, e.is_err ? "err" : "done", e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_mem_wr(int a, logic [DW-1:0] d);
    mem_wr_en = 1'b1; mem_addr = MAW'(a); mem_wdata = d;
    tick();
    mem_wr_en = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic check_mem(int a);
    mem_addr = MAW'(a);
    tick();
    check("mem_rdata", mem_rdata, m_mem[a]);
  endtask

  task automatic host_reg_wr(int a, logic [DW-1:0] d);
    reg_wr_en = 1'b1; reg_waddr = RAW'(a); reg_wdata = d;
    tick();
    reg_wr_en = 1'b0;
    m_reg[a] = d;
  endtask

  task automatic check_regs();
    for (int b = 0; b < RDEP; b += NRD) begin
      for (int j = 0; j < NRD; j++) reg_raddr[j*RAW +: RAW] = RAW'((b + j) % RDEP);
      #1;
      for (int j = 0; j < NRD; j++)
        check("reg_rdata", reg_rdata[j*DW +: DW], m_reg[(b + j) % RDEP]);
      tick();
    end
  endtask

  // Drives a one-cycle start and records the outcome the rules predict.
  task automatic issue_start(bit dir, int mb, int rb, int len, bit idle_now,
                             output int t0, output int exp_busy);
    bit legal = idle_now && len <= RDEP;
    t0 = cyc;
    xfer_start = 1'b1; xfer_dir = dir; xfer_mem_base = MAW'(mb);
    xfer_reg_base = RAW'(rb); xfer_len = (RAW+1)'(len);
    if (!legal) begin
      push_ev(1'b1, t0 + 1);
      exp_busy = 0;
    end else begin
      exp_busy = (len == 0) ? 1 : (dir ? len + 1 : len + 2);
      push_ev(1'b0, t0 + exp_busy);
      for (int i = 0; i < len; i++) begin
        if (dir) m_mem[(mb + i) % MDEP] = m_reg[(rb + i) % RDEP];
        else     m_reg[(rb + i) % RDEP] = m_mem[(mb + i) % MDEP];
      end
    end
    tick();
    xfer_start = 1'b0;
  endtask

  task automatic wait_idle(string name, int t0, int exp_busy);
    int n = 0;
    while (xfer_busy && n < 100) begin
      tick();
      n++;
    end
    check(name, cyc - t0 - 1, exp_busy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, eb, dummy_t, dummy_b;
    rst = 1'b1; mem_wr_en = 0; mem_addr = '0; mem_wdata = '0;
    reg_wr_en = 0; reg_waddr = '0; reg_wdata = '0; reg_raddr = '0;
    xfer_start = 0; xfer_dir = 0; xfer_mem_base = '0; xfer_reg_base = '0; xfer_len = '0;
    for (int i = 0; i < RDEP; i++) m_reg[i] = '0;
    repeat (3) tick();
    check("rst_busy", xfer_busy, 0);
    check("rst_done", xfer_done, 0);
    check("rst_err", xfer_err, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    rst = 1'b0;
    for (int a = 0; a < MDEP; a++) host_mem_wr(a, $urandom);
    check_regs();

    // Host read latency and read-first collision
    host_mem_wr(5, 29839);
    check_mem(5);
    mem_wr_en = 1'b1; mem_addr = 5; mem_wdata = 7;
    tick();
    mem_wr_en = 1'b0;
    check("read_first", mem_rdata, 29839);
    m_mem[5] = 7;
    check_mem(5);

    // Register write forwarding
    reg_wr_en = 1'b1; reg_waddr = 9; reg_wdata = 32'h55; reg_raddr[RAW-1:0] = 9;
    #1;
    check("reg_forward", reg_rdata[DW-1:0], 32'h55);
    tick();
    reg_wr_en = 1'b0;
    m_reg[9] = 32'h55;

    // Load with a rejected start, dropped host writes and held mem_rdata
    host_mem_wr(100, 11); host_mem_wr(101, 22); host_mem_wr(102, 33); host_mem_wr(103, 44);
    mem_addr = 200;
    issue_start(1'b0, 100, 4, 4, 1'b1, t0, eb);
    issue_start(1'b1, 0, 0, 2, 1'b0, dummy_t, dummy_b);
    mem_addr = 300; mem_wr_en = 1'b1; mem_wdata = 32'hBEEF;
    reg_wr_en = 1'b1; reg_waddr = 20; reg_wdata = 32'hDEAD;
    tick();
    mem_wr_en = 1'b0; reg_wr_en = 1'b0;
    check("rdata_hold", mem_rdata, m_mem[200]);
    wait_idle("load_busy_cycles", t0, eb);
    reg_raddr = {5'd7, 5'd5, 5'd4};
    #1;
    check("load_r4", reg_rdata[0 +: DW], 11);
    check("load_r5", reg_rdata[DW +: DW], 22);
    check("load_r7", reg_rdata[2*DW +: DW], 44);
    tick();
    check_regs();
    check_mem(300);

    // Store wrapping both address spaces
    host_reg_wr(30, 32'hA); host_reg_wr(31, 32'hB); host_reg_wr(0, 32'hC);
    issue_start(1'b1, 1022, 30, 3, 1'b1, t0, eb);
    wait_idle("store_busy_cycles", t0, eb);
    check_mem(1022); check_mem(1023); check_mem(0);
    check("store_wrap_mem0", mem_rdata, 32'hC);

    // Over-length rejection and zero-length transfer
    issue_start(1'b0, 10, 3, 33, 1'b1, t0, eb);
    wait_idle("len33_busy", t0, eb);
    issue_start(1'b1, 50, 2, 0, 1'b1, t0, eb);
    wait_idle("len0_busy", t0, eb);
    check_mem(50);
    check_regs();

    // Randomized transfers against the model
    for (int it = 0; it < 25; it++) begin
      int dir, mb, rb, len;
      if ($urandom_range(0, 2) == 0) host_reg_wr($urandom_range(0, RDEP - 1), $urandom);
      dir = $urandom_range(0, 1);
      mb  = $urandom_range(0, MDEP - 1);
      rb  = $urandom_range(0, RDEP - 1);
      len = $urandom_range(0, 40);
      issue_start(dir[0], mb, rb, len, 1'b1, t0, eb);
      wait_idle("rand_busy_cycles", t0, eb);
      check_regs();
      if (dir == 1 && len <= RDEP)
        for (int i = 0; i < len; i++) check_mem((mb + i) % MDEP);
    end

    // Reset during the second RUN cycle of a length-8 load
    xfer_start = 1'b1; xfer_dir = 1'b0; xfer_mem_base = 600; xfer_reg_base = 0; xfer_len = 8;
    tick();
    xfer_start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", xfer_busy, 0);
    for (int i = 0; i < RDEP; i++) m_reg[i] = '0;
    repeat (12) tick();
    check_regs();
    for (int i = 0; i < 8; i++) check_mem(600 + i);

    repeat (4) tick();
    check("pending_events", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_reg_xfer.md
Name: mem_reg_xfer

Overview:
- Parametrised data-memory plus multi-port register-file subsystem, generalising the fixed 10-bit-address / 32-bit / 3-read-port storage pair.
- Adds a block-transfer engine that copies bursts between memory and register file (load or store) under a start/busy/done handshake.
- Sits between the datapath (register read ports) and the test/host control that fills memory.

Parameters:
- DATA_W, 32, data word width
- MEM_AW, 10, memory address width; depth 2**MEM_AW
- REG_AW, 5, register address width; depth 2**REG_AW
- NUM_RD, 3, number of combinational register read ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_wr_en  in  1  host memory write
- mem_addr  in  MEM_AW  host memory address (read and write)
- mem_wdata  in  DATA_W  host memory write data
- mem_rdata  out  DATA_W  registered host memory read data
- reg_wr_en  in  1  host register write
- reg_waddr  in  REG_AW  host register write address
- reg_wdata  in  DATA_W  host register write data
- reg_raddr  in  NUM_RD*REG_AW  packed read addresses; port i at bits [i*REG_AW +: REG_AW]
- reg_rdata  out  NUM_RD*DATA_W  packed read data, same packing
- xfer_start  in  1  request a transfer (sampled in IDLE only)
- xfer_dir  in  1  0 = load (mem->reg), 1 = store (reg->mem)
- xfer_mem_base  in  MEM_AW  first memory address
- xfer_reg_base  in  REG_AW  first register address
- xfer_len  in  REG_AW+1  word count, 0..2**REG_AW
- xfer_busy  out  1  engine active
- xfer_done  out  1  one-cycle completion pulse
- xfer_err  out  1  one-cycle rejection pulse

Behaviour:
- Reset: FSM to IDLE; xfer_busy, xfer_done, xfer_err = 0; mem_rdata = 0; all registers cleared to 0. Memory contents are not reset.
- Host memory read: mem_rdata <= mem[mem_addr] every cycle while IDLE, with 1-cycle latency. A write and read to the same address in the same cycle is read-first (returns old data). While busy, mem_rdata holds its value.
- Register reads are combinational. A same-cycle write to the same address is forwarded, so the new data appears on reg_rdata. The forwarding source is the host write when IDLE and the engine write when busy.
- Host writes (mem_wr_en, reg_wr_en) take effect only in IDLE. While busy they are dropped silently; no queueing.
- FSM states:
  - IDLE:
    - On xfer_start with xfer_len > 2**REG_AW: pulse xfer_err, stay IDLE.
    - On xfer_start with xfer_len == 0: go to DONE (no array access).
    - On any other xfer_start: latch base/len/dir, clear counter k, go to RUN.
  - RUN (store): each cycle mem[mb+k] <= reg[rb+k]; k++. After the write with k == len-1, go to DONE. Occupies len cycles.
  - RUN (load): each cycle issue a memory read at mb+k. Data returns the next cycle and writes reg[rb+k_prev]. After the last read is issued, go to DRAIN.
  - DRAIN: perform the final register write, go to DONE. A load therefore occupies len+1 cycles.
  - DONE: xfer_done = 1 for exactly one cycle, then IDLE.
- xfer_busy = 1 in RUN, DRAIN and DONE. The earliest new start is accepted the cycle after DONE.
- xfer_start while busy: ignored and xfer_err pulses. The running transfer is unaffected.
- Addresses wrap modulo depth: mb+k modulo 2**MEM_AW, rb+k modulo 2**REG_AW. A register wrap onto already-written entries is permitted and the last write wins.
- xfer_err and xfer_done are never asserted in the same cycle.
- rst asserted mid-transfer: immediate return to IDLE and no done pulse. Memory writes already made remain; registers clear per reset.

Decomposition:
- Package mem_reg_pkg holds:
  - the xfer_state_e enum (IDLE, RUN, DRAIN, DONE);
  - XFER_LOAD/XFER_STORE constants;
  - default width constants.
- One sub-module, mem_reg_regfile:
  - NUM_RD combinational read ports, one write port, forwarding, synchronous clear.
  - The top muxes host vs engine onto its write port.
- The memory is inferred inline in the top as a single-port synchronous array.

Test Plan:
- Host fill then read: write mem[5]=29839 with mem_wr_en and addr 5; next cycle read addr 5 -> mem_rdata = 29839 one cycle later. A same-cycle write of 7 to addr 5 while reading 5 returns 29839.
- Load: mem[100..103] = 11,22,33,44; start dir=0, mem_base=100, reg_base=4, len=4 -> busy for 6 cycles, done pulse once; reg_rdata port0..2 at regs 4,5,7 = 11,22,44.
- Store with wrap:
  - regs 30, 31, 0 = 0xA, 0xB, 0xC; start dir=1, mem_base=1022, reg_base=30, len=3.
  - Required result: mem[1022], mem[1023], mem[0] = 0xA, 0xB, 0xC; done after 3 RUN cycles.
- Errors and len 0:
  - len=33 -> err pulse, busy stays 0.
  - Start during a busy load -> err pulse, original load completes correctly.
  - len=0 -> done pulse the cycle after start, no writes.
- Forwarding and drop:
  - reg_wr_en to reg 9 = 0x55 with raddr0=9 -> reg_rdata0 = 0x55 same cycle.
  - reg_wr_en during busy -> register unchanged.
- Reset mid-load: assert rst during RUN cycle 2 of a len=8 load -> next cycle busy=0, done never pulses, all regs read 0, memory unchanged.
